br_redirect: RTL and testbench
==============================

// Module: br_redirect
// PURPOSE
//  Downstream consumer of the pcrel/ALU exec_result stream. Retires results into the
//  register-file write port and turns taken branches / jumps / exceptions into a held
//  fetch redirect plus a one-cycle pipeline flush. Sits between execute and fetch/regfile.
// PARAMETERS
//  XLEN      32            width of addr / gpreg
//  TRAP_VEC  32'h0000_0100 redirect target on exception
// PORTS
//  clk             in   1     clock (single clock domain)
//  rst             in   1     asynchronous, active-high reset
//  res_valid       in   1     exec_result valid
//  res_ready       out  1     accept; fire = res_valid & res_ready
//  res_rd_wen      in   1     instr writes rd (AUIPC/JAL=1, BRANCH=0)
//  res_rd_idx      in   5     exec_result.rd_idx
//  res_rd_val      in   XLEN  exec_result.rd_val
//  res_br_valid    in   1     exec_result.br_valid (taken)
//  res_br_target   in   XLEN  exec_result.br_target
//  res_ex_valid    in   1     exec_result.ex_valid
//  res_ex          in   XLEN  exec_result.ex cause
//  rf_we           out  1     regfile write enable (registered)
//  rf_idx          out  5     regfile write index
//  rf_val          out  XLEN  regfile write data
//  redir_valid     out  1     fetch redirect request
//  redir_ready     in   1     fetch accepts redirect
//  redir_pc        out  XLEN  new fetch PC
//  flush           out  1     one-cycle squash of younger in-flight instrs
//  ex_cause        out  XLEN  cause of last exception redirect (held)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; rf_we=0, rf_idx=0, rf_val=0, redir_valid=0,
//   redir_pc=0, flush=0, ex_cause=0; res_ready=0 while rst high.
//  FSM: IDLE -> REDIR -> FLUSH -> IDLE.
//   IDLE : res_ready=1. On fire:
//     ex_valid            -> redir_pc<=TRAP_VEC, ex_cause<=res_ex, no rf write, ->REDIR
//     else br_valid       -> redir_pc<=br_target, rf write if rd_wen, ->REDIR
//     else                -> rf write if rd_wen, stay IDLE
//     Priority: ex_valid > br_valid > plain writeback.
//   REDIR: redir_valid=1, res_ready=0; redir_pc/valid held stable until redir_ready.
//     redir_valid&redir_ready -> FLUSH (accept may occur on first REDIR cycle).
//   FLUSH: flush=1 exactly one cycle, res_ready=0, redir_valid=0 -> IDLE.
//  Latency: rf_* registered, valid cycle after fire; redir_valid rises cycle after
//   fire; min fire-to-next-accept for redirect = 3 cycles (REDIR, FLUSH, IDLE).
//  rf_we forced 0 when rd_idx==0 (x0 never written); rf_we is a 1-cycle pulse per fire.
//  res_* sampled only on fire; inputs while res_ready=0 are ignored (producer holds).
//  Reset mid-REDIR/FLUSH: redirect dropped, flush not issued, returns to IDLE.
//  Back-to-back non-redirect results: one per cycle, no bubbles.
// CONFIGURATION
//  BR_REDIRECT_ALIGN_CHECK_EN defined: in IDLE, br_valid & ~ex_valid &
//   br_target[1:0]!=0 treated as exception: redir_pc<=TRAP_VEC, ex_cause<=0
//   (instr-addr-misaligned), rd write suppressed.
//  Undefined: target used unchanged, no alignment check logic.
// TESTING
//  AUIPC: rd_wen=1,idx=5,val=32'h1000,br=0 -> next cycle rf_we=1,idx=5,val=1000; no redir.
//  JAL: idx=1,val=32'h84,br=1,target=32'h200 -> rf write x1=84; redir_pc=200 held
//   with redir_ready=0 for 3 cycles; ready=1 -> flush=1 next cycle, then res_ready=1.
//  BEQ not taken: rd_wen=0,br=0 -> no rf_we, no redir; 4 back-to-back -> 4 accepts.
//  ex_valid=1,br=1,ex=2 -> redir_pc=TRAP_VEC, ex_cause=2, rf_we=0.
//  rst pulsed while in REDIR -> redir_valid=0, flush=0, res_ready=1 after release.
//  ALIGN_CHECK_EN: br=1,target=32'h202,rd_wen=1 -> redir_pc=TRAP_VEC, ex_cause=0,
//   rf_we=0; without macro -> redir_pc=202, rf write occurs.

Source files
------------

// File: rtl/br_redirect.sv
// ---------------------------------------------------------------------------
// br_redirect
//
// Purpose:
//   Final consumer of the execute-stage result stream. Every accepted result
//   can retire a register-file write, and a taken branch/jump or an exception
//   is turned into a fetch redirect. The redirect is held until fetch accepts
//   it, and is then followed by a single-cycle flush of younger instructions.
//
//   Sequence for a redirecting result:
//     IDLE (fire) -> REDIR (redir_valid held) -> FLUSH (flush pulse) -> IDLE
//   Results that do not redirect stay in IDLE, one per cycle, with no bubbles.
//
// Optional feature (compile-time macro):
//   BR_REDIRECT_ALIGN_CHECK_EN
//     Defined   : a taken branch whose target is not word aligned becomes an
//                 instruction-address-misaligned exception (cause 0). It
//                 redirects to TRAP_VEC and its rd write is suppressed.
//     Undefined : branch targets are used unchanged and no check is built.
//
// Parameters:
//   XLEN      width of addresses and general-purpose register data
//   TRAP_VEC  fetch target used for every exception redirect
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   res_valid / res_ready    result handshake (fire = res_valid & res_ready)
//   res_rd_wen/idx/val       destination register write request
//   res_br_valid/target      taken branch/jump and its target
//   res_ex_valid / res_ex    exception flag and cause
//   rf_we/idx/val            registered regfile write port (1-cycle pulse)
//   redir_valid / redir_ready / redir_pc   fetch redirect handshake
//   flush                    one-cycle squash of younger in-flight instrs
//   ex_cause                 cause of the last exception redirect (held)
// ---------------------------------------------------------------------------
module br_redirect #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            res_valid,
  output logic            res_ready,
  input  logic            res_rd_wen,
  input  logic [4:0]      res_rd_idx,
  input  logic [XLEN-1:0] res_rd_val,
  input  logic            res_br_valid,
  input  logic [XLEN-1:0] res_br_target,
  input  logic            res_ex_valid,
  input  logic [XLEN-1:0] res_ex,

  output logic            rf_we,
  output logic [4:0]      rf_idx,
  output logic [XLEN-1:0] rf_val,

  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,

  output logic            flush,
  output logic [XLEN-1:0] ex_cause
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_reg;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // Results are only taken in IDLE. Qualifying with rst keeps the producer
  // from seeing an accept while reset is still asserted.
  assign res_ready = (state_reg == S_IDLE) && !rst;

  logic fire;
  assign fire = res_valid && res_ready;

  logic redir_accept;
  assign redir_accept = redir_valid && redir_ready;

  // -------------------------------------------------------------------------
  // Result classification (only meaningful when fire is high)
  // -------------------------------------------------------------------------
  logic            take_trap;
  logic            take_branch;
  logic            do_write;
  logic [XLEN-1:0] trap_cause;

  always_comb begin
    take_trap  = res_ex_valid;
    trap_cause = res_ex;

`ifdef BR_REDIRECT_ALIGN_CHECK_EN
    // A misaligned taken branch is reported as cause 0 unless a real
    // exception already takes priority.
    if (res_br_valid && !res_ex_valid && (res_br_target[1:0] != 2'b00)) begin
      take_trap  = 1'b1;
      trap_cause = '0;
    end
`endif

    take_branch = res_br_valid && !take_trap;

    // x0 is hardwired to zero, and a trapping instruction never retires.
    do_write = res_rd_wen && (res_rd_idx != 5'd0) && !take_trap;
  end

  // -------------------------------------------------------------------------
  // State machine with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      rf_we       <= 1'b0;
      rf_idx      <= 5'd0;
      rf_val      <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      flush       <= 1'b0;
      ex_cause    <= '0;
    end else begin
      // rf_we is a pulse; it is only raised on the cycle after a fire.
      rf_we <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          flush <= 1'b0;
          if (fire) begin
            rf_we <= do_write;
            if (do_write) begin
              rf_idx <= res_rd_idx;
              rf_val <= res_rd_val;
            end

            if (take_trap) begin
              redir_pc    <= TRAP_VEC;
              ex_cause    <= trap_cause;
              redir_valid <= 1'b1;
              state_reg   <= S_REDIR;
            end else if (take_branch) begin
              redir_pc    <= res_br_target;
              redir_valid <= 1'b1;
              state_reg   <= S_REDIR;
            end
          end
        end

        S_REDIR: begin
          // redir_pc and redir_valid stay untouched until fetch accepts.
          if (redir_accept) begin
            redir_valid <= 1'b0;
            flush       <= 1'b1;
            state_reg   <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          flush     <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          redir_valid <= 1'b0;
          flush       <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_redirect.sv
module tb_br_redirect;

  localparam int          XLEN     = 32;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic            clk;
  logic            rst;
  logic            res_valid;
  logic            res_ready;
  logic            res_rd_wen;
  logic [4:0]      res_rd_idx;
  logic [XLEN-1:0] res_rd_val;
  logic            res_br_valid;
  logic [XLEN-1:0] res_br_target;
  logic            res_ex_valid;
  logic [XLEN-1:0] res_ex;
  logic            rf_we;
  logic [4:0]      rf_idx;
  logic [XLEN-1:0] rf_val;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;
  logic            flush;
  logic [XLEN-1:0] ex_cause;

  br_redirect #(.XLEN(XLEN), .TRAP_VEC(TRAP_VEC)) dut (
    .clk           (clk),
    .rst           (rst),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_rd_wen    (res_rd_wen),
    .res_rd_idx    (res_rd_idx),
    .res_rd_val    (res_rd_val),
    .res_br_valid  (res_br_valid),
    .res_br_target (res_br_target),
    .res_ex_valid  (res_ex_valid),
    .res_ex        (res_ex),
    .rf_we         (rf_we),
    .rf_idx        (rf_idx),
    .rf_val        (rf_val),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc),
    .flush         (flush),
    .ex_cause      (ex_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: expected regfile writes {idx,val} and expected redirect PCs.
  logic [36:0] rfq[$];
  logic [31:0] rq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: retire writes, accepted redirects, flush.
  logic acc_prev = 1'b0;
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (rfq.size() == 0) begin
        check("rf_we_spurious", {31'd0, rf_we}, 32'd0);
      end else begin
        logic [36:0] e;
        e = rfq.pop_front();
        check("rf_idx", {27'd0, rf_idx}, {27'd0, e[36:32]});
        check("rf_val", rf_val, e[31:0]);
        $display("RFWRITE t=%0t idx=%0d val=%h", $time, rf_idx, rf_val);
      end
    end
    check("flush", {31'd0, flush}, {31'd0, acc_prev});
    if (redir_valid === 1'b1 && redir_ready === 1'b1) begin
      if (rq.size() == 0) begin
        check("redir_spurious", {31'd0, redir_valid}, 32'd0);
      end else begin
        logic [31:0] p;
        p = rq.pop_front();
        check("redir_pc", redir_pc, p);
        $display("REDIRECT t=%0t pc=%h", $time, redir_pc);
      end
    end
    acc_prev = (redir_valid === 1'b1) && (redir_ready === 1'b1) && !rst;
  end

  // Drive one result and wait (bounded) for it to fire; push expectations.
  task automatic send(input logic wen, input logic [4:0] idx, input logic [31:0] val,
                      input logic br, input logic [31:0] tgt,
                      input logic exv, input logic [31:0] exc);
    logic trap;
    logic [1:0] lo;
    bit done;
    res_valid     = 1'b1;
    res_rd_wen    = wen;
    res_rd_idx    = idx;
    res_rd_val    = val;
    res_br_valid  = br;
    res_br_target = tgt;
    res_ex_valid  = exv;
    res_ex        = exc;
    trap = exv;
    lo   = tgt[1:0];
`ifdef BR_REDIRECT_ALIGN_CHECK_EN
    if (br && !exv && lo != 2'b00) trap = 1'b1;
`endif
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (res_ready === 1'b1) begin
        if (trap) rq.push_back(TRAP_VEC);
        else if (br) rq.push_back(tgt);
        if (wen && idx != 5'd0 && !trap) rfq.push_back({idx, val});
        $display("SEND t=%0t wen=%0d idx=%0d val=%h br=%0d tgt=%h ex=%0d cause=%h",
                 $time, wen, idx, val, br, tgt, exv, exc);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    res_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    res_valid = 0; res_rd_wen = 0; res_rd_idx = 0; res_rd_val = 0;
    res_br_valid = 0; res_br_target = 0; res_ex_valid = 0; res_ex = 0;
    redir_ready = 0;
    #2;
    check("rst_res_ready",   {31'd0, res_ready},   32'd0);
    check("rst_rf_we",       {31'd0, rf_we},       32'd0);
    check("rst_rf_idx",      {27'd0, rf_idx},      32'd0);
    check("rst_rf_val",      rf_val,               32'd0);
    check("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_redir_pc",    redir_pc,             32'd0);
    check("rst_ex_cause",    ex_cause,             32'd0);
    tick(2);
    rst = 1'b0;
    #1;
    check("idle_res_ready", {31'd0, res_ready}, 32'd1);

    // AUIPC x5
    send(1, 5'd5, 32'h0000_1000, 0, 32'h0, 0, 32'h0);
    check("auipc_no_redir", {31'd0, redir_valid}, 32'd0);
    tick(1);

    // write to x0 is discarded
    send(1, 5'd0, 32'hdead_beef, 0, 32'h0, 0, 32'h0);
    tick(1);

    // JAL x1, target 0x200, fetch stalls 3 cycles
    send(1, 5'd1, 32'h0000_0084, 1, 32'h0000_0200, 0, 32'h0);
    check("jal_redir_valid", {31'd0, redir_valid}, 32'd1);
    check("jal_redir_pc",    redir_pc, 32'h0000_0200);
    check("jal_busy",        {31'd0, res_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("jal_hold_valid", {31'd0, redir_valid}, 32'd1);
      check("jal_hold_pc",    redir_pc, 32'h0000_0200);
      check("jal_hold_busy",  {31'd0, res_ready}, 32'd0);
    end
    redir_ready = 1'b1;
    tick(1);
    redir_ready = 1'b0;
    check("jal_flush",       {31'd0, flush},       32'd1);
    check("jal_flush_rv",    {31'd0, redir_valid}, 32'd0);
    check("jal_flush_busy",  {31'd0, res_ready},   32'd0);
    tick(1);
    check("jal_flush_off",   {31'd0, flush},       32'd0);
    check("jal_ready_again", {31'd0, res_ready},   32'd1);

    // BEQ not taken x4 back-to-back
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(0, 5'd2, 32'h0, 0, 32'h0, 0, 32'h0);
    check("beq_b2b_cycles", cyc - c0, 32'd4);

    // AUIPC x4 back-to-back, distinct destinations
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      send(1, 5'(10 + i), 32'h0000_a000 + 32'(i), 0, 32'h0, 0, 32'h0);
    check("wb_b2b_cycles", cyc - c0, 32'd4);
    tick(1);

    // exception beats branch; fetch accepts on the first REDIR cycle
    redir_ready = 1'b1;
    send(1, 5'd3, 32'h0000_0033, 1, 32'h0000_0300, 1, 32'h0000_0002);
    check("ex_redir_pc",  redir_pc, TRAP_VEC);
    check("ex_cause",     ex_cause, 32'h0000_0002);
    check("ex_rvalid",    {31'd0, redir_valid}, 32'd1);
    tick(1);
    check("ex_flush",     {31'd0, flush}, 32'd1);
    tick(1);
    check("ex_ready",     {31'd0, res_ready}, 32'd1);
    redir_ready = 1'b0;

    // misaligned branch target
    send(1, 5'd7, 32'h0000_0055, 1, 32'h0000_0202, 0, 32'h0);
`ifdef BR_REDIRECT_ALIGN_CHECK_EN
    check("mis_redir_pc", redir_pc, TRAP_VEC);
    check("mis_ex_cause", ex_cause, 32'h0);
`else
    check("mis_redir_pc", redir_pc, 32'h0000_0202);
    check("mis_ex_cause", ex_cause, 32'h0000_0002);
`endif
    redir_ready = 1'b1;
    tick(2);
    redir_ready = 1'b0;
    check("mis_ready", {31'd0, res_ready}, 32'd1);

    // reset while a redirect is pending
    send(0, 5'd0, 32'h0, 1, 32'h0000_0400, 0, 32'h0);
    check("rr_valid_before", {31'd0, redir_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rr_valid_rst",  {31'd0, redir_valid}, 32'd0);
    check("rr_ready_rst",  {31'd0, res_ready},   32'd0);
    check("rr_cause_rst",  ex_cause,             32'd0);
    rq.delete();
    tick(1);
    rst = 1'b0;
    #1;
    check("rr_ready_after", {31'd0, res_ready},   32'd1);
    check("rr_valid_after", {31'd0, redir_valid}, 32'd0);
    check("rr_flush_after", {31'd0, flush},       32'd0);

    // normal operation after reset
    send(1, 5'd9, 32'h1234_5678, 0, 32'h0, 0, 32'h0);
    tick(3);
    check("rfq_drained", rfq.size(), 32'd0);
    check("rq_drained",  rq.size(),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
